// File: rtl/spi_target_to_streams1.sv
// SPI mode-0 target front end: oversamples SCK/CS_n/MOSI in the CLK domain and
// turns each transaction into a received byte stream plus a transmit byte pull.
module spi_target_to_streams1 #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SCK,
  input  logic       CS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_OE,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_last,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       overflow,
  output logic       underrun
);

  typedef enum logic [1:0] {HOLD_EMPTY, HOLD_OPEN, HOLD_LAST} hold_state_t;

  logic [SYNC_STAGES-1:0] sck_sr, cs_sr, mosi_sr, fill_sr;
  logic                   sck_prev, sck_s, cs_s, mosi_s;
  logic                   armed, ld_pend;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_shift, tx_shift, h_data, rx_byte, load_val;
  logic                   busy_d, start, stop, active, rise, fall;
  logic                   byte_done, load, o_free, move, move_last, store, drop;
  hold_state_t            hold_st, hold_nx;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sck_sr   <= '0;
      cs_sr    <= '1;
      mosi_sr  <= '0;
      fill_sr  <= '0;
      sck_prev <= 1'b0;
    end else begin
      sck_sr   <= {sck_sr[SYNC_STAGES-2:0], SCK};
      cs_sr    <= {cs_sr[SYNC_STAGES-2:0], CS_n};
      mosi_sr  <= {mosi_sr[SYNC_STAGES-2:0], MOSI};
      fill_sr  <= {fill_sr[SYNC_STAGES-2:0], 1'b1};
      sck_prev <= sck_sr[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sck_s     = sck_sr[SYNC_STAGES-1];
    cs_s      = cs_sr[SYNC_STAGES-1];
    mosi_s    = mosi_sr[SYNC_STAGES-1];
    busy_d    = ~cs_s & (busy | armed);
    start     = busy_d & ~busy;
    stop      = busy & ~busy_d;
    active    = busy & busy_d;
    rise      = active & sck_s & ~sck_prev;
    fall      = active & ~sck_s & sck_prev;
    byte_done = rise & (bit_cnt == 3'd7);
    load      = start | (fall & ld_pend);
    tx_ready  = load & tx_valid;
    load_val  = tx_valid ? tx_data : FILL_BYTE;
    rx_byte   = {rx_shift[6:0], mosi_s};
    MISO_OE   = busy;
  end

  // The reset value of the CS_n synchroniser reads as "high"; arming waits until
  // the pipeline holds real samples so a reset under a held-low CS_n stays idle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      armed    <= 1'b0;
      busy     <= 1'b0;
      bit_cnt  <= '0;
      ld_pend  <= 1'b0;
      rx_shift <= '0;
      tx_shift <= '0;
      MISO     <= 1'b0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      armed <= armed | (cs_s & fill_sr[SYNC_STAGES-1]);
      busy  <= busy_d;
      if (start || stop) begin
        bit_cnt <= '0;
        ld_pend <= 1'b0;
      end else if (rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_byte;
        if (bit_cnt == 3'd7) ld_pend <= 1'b1;
      end else if (fall && ld_pend) begin
        ld_pend <= 1'b0;
      end
      if (load) begin
        tx_shift <= load_val;
        MISO     <= load_val[7];
      end else if (fall) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
        MISO     <= tx_shift[6];
      end else if (stop) begin
        MISO <= 1'b0;
      end
      if (start)     overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
      if (load && !tx_valid) underrun <= 1'b1;
      else if (start)        underrun <= 1'b0;
    end
  end

  // A completed byte waits in the hold slot until its last status is known; it
  // advances to the offer register only when that register is free or draining.
  always_comb begin
    o_free    = ~rx_valid | rx_ready;
    move      = o_free & ((hold_st == HOLD_LAST) | ((hold_st == HOLD_OPEN) & (rise | stop)));
    move_last = (hold_st == HOLD_LAST) | stop;
    store     = byte_done & ((hold_st == HOLD_EMPTY) | move);
    drop      = byte_done & ~store;
    hold_nx   = hold_st;
    if (store)                                hold_nx = HOLD_OPEN;
    else if (move)                            hold_nx = HOLD_EMPTY;
    else if ((hold_st == HOLD_OPEN) && stop)  hold_nx = HOLD_LAST;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) hold_st <= HOLD_EMPTY;
    else       hold_st <= hold_nx;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      h_data   <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_last  <= 1'b0;
    end else begin
      if (store) h_data <= rx_byte;
      if (move) begin
        rx_valid <= 1'b1;
        rx_data  <= h_data;
        rx_last  <= move_last;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_target_to_streams1.sv
// Self-checking bench for spi_target_to_streams1: drives SPI mode-0 transactions
// and compares the byte streams against a buffer-capacity reference model.
module tb_spi_target_to_streams1;

  logic       CLK, RESET, SCK, CS_n, MOSI, MISO, MISO_OE;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_ready, rx_last, tx_valid, tx_ready;
  logic       busy, overflow, underrun;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned sck_rises = 0;
  int unsigned tx_pulses = 0;
  logic        busy_seen = 1'b0;

  typedef struct {
    logic [7:0]  d;
    logic        l;
    int unsigned r;
    logic        cs;
  } rx_rec_t;

  rx_rec_t    got[$];
  logic [7:0] tx_q[$];

  spi_target_to_streams1 #(.SYNC_STAGES(2), .FILL_BYTE(8'hFF)) dut (
    .CLK(CLK), .RESET(RESET), .SCK(SCK), .CS_n(CS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_last(rx_last), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .overflow(overflow), .underrun(underrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (rx_valid && rx_ready) got.push_back('{rx_data, rx_last, sck_rises, CS_n});
    if (busy) busy_seen = 1'b1;
  end

  function automatic void drive_tx();
    tx_valid = (tx_q.size() != 0);
    tx_data  = tx_valid ? tx_q[0] : 8'h00;
  endfunction

  always @(negedge CLK) begin
    if (tx_ready) begin
      tx_pulses++;
      @(posedge CLK);
      #1;
      if (tx_q.size() != 0) void'(tx_q.pop_front());
      drive_tx();
    end
  end

  task automatic cs_low();
    sck_rises = 0;
    CS_n = 1'b0;
    #100;
  endtask

  task automatic cs_high();
    #60;
    CS_n = 1'b1;
    #100;
  endtask

  task automatic xfer_bit(input logic b, output logic m);
    MOSI = b;
    #60;
    m = MISO;
    SCK = 1'b1;
    sck_rises++;
    #60;
    SCK = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] b, output logic [7:0] m);
    logic mb;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(b[i], mb);
      m[i] = mb;
    end
  endtask

  task automatic test_reset();
    #23;
    checks++;
    if ({MISO, MISO_OE, rx_valid, busy, tx_ready, overflow, underrun} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=0000000",
               {MISO, MISO_OE, rx_valid, busy, tx_ready, overflow, underrun});
    end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    #100;
    checks++;
    if ({busy, MISO_OE} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset busy/oe=%b want=00", {busy, MISO_OE});
    end
  endtask

  task automatic test_rx_stream();
    logic [7:0] b[$];
    logic [7:0] m;
    int unsigned n;
    for (int t = 0; t < 2; t++) begin
      b.delete();
      if (t == 0) b = '{8'h10, 8'hA5, 8'h3C};
      else begin
        n = $urandom_range(1, 4);
        for (int i = 0; i < int'(n); i++) b.push_back(8'($urandom));
      end
      rx_ready = 1'b1;
      got.delete();
      cs_low();
      foreach (b[i]) xfer_byte(b[i], m);
      cs_high();
      checks++;
      if (got.size() !== b.size()) begin
        errors++;
        $display("FAIL rx_count t=%0d got=%0d want=%0d", t, got.size(), b.size());
      end else begin
        foreach (b[i]) begin
          checks++;
          if (got[i].d !== b[i] || got[i].l !== logic'(i == b.size() - 1)) begin
            errors++;
            $display("FAIL rx_byte t=%0d i=%0d got=%h/%b want=%h/%b", t, i,
                     got[i].d, got[i].l, b[i], logic'(i == b.size() - 1));
          end
          checks++;
          if (i == b.size() - 1 ? got[i].cs !== 1'b1 : got[i].r <= 8 * (i + 1)) begin
            errors++;
            $display("FAIL rx_timing t=%0d i=%0d rises=%0d cs=%b", t, i, got[i].r, got[i].cs);
          end
        end
      end
      checks++;
      if (overflow !== 1'b0) begin
        errors++;
        $display("FAIL rx_no_overflow got=%b want=0", overflow);
      end
    end
  endtask

  task automatic test_tx();
    logic [7:0] d0, d1, m0, m1;
    for (int t = 0; t < 2; t++) begin
      d0 = (t == 0) ? 8'hC3 : 8'($urandom);
      d1 = (t == 0) ? 8'h5A : 8'($urandom);
      tx_q = '{d0, d1};
      drive_tx();
      tx_pulses = 0;
      cs_low();
      xfer_byte(8'($urandom), m0);
      xfer_byte(8'($urandom), m1);
      cs_high();
      checks++;
      if ({m0, m1} !== {d0, d1}) begin
        errors++;
        $display("FAIL tx_miso t=%0d got=%h want=%h", t, {m0, m1}, {d0, d1});
      end
      checks++;
      if (tx_pulses !== 2) begin
        errors++;
        $display("FAIL tx_pulses t=%0d got=%0d want=2", t, tx_pulses);
      end
    end
  endtask

  task automatic test_underrun();
    logic [7:0] m0, m1, x;
    tx_q.delete();
    drive_tx();
    cs_low();
    xfer_byte(8'($urandom), m0);
    xfer_byte(8'($urandom), m1);
    cs_high();
    checks++;
    if ({m0, m1} !== 16'hFFFF) begin
      errors++;
      $display("FAIL underrun_fill got=%h want=ffff", {m0, m1});
    end
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_set got=%b want=1", underrun);
    end
    x = 8'($urandom);
    tx_q.push_back(x);
    drive_tx();
    cs_low();
    checks++;
    if (underrun !== 1'b0 || MISO !== x[7]) begin
      errors++;
      $display("FAIL underrun_clear underrun=%b miso=%b want 0/%b", underrun, MISO, x[7]);
    end
    cs_high();
  endtask

  task automatic test_overflow();
    logic [7:0] b[$];
    logic [7:0] m;
    int unsigned n, del;
    for (int t = 0; t < 2; t++) begin
      n = (t == 0) ? 4 : $urandom_range(1, 5);
      del = (n < 2) ? n : 2;
      b.delete();
      for (int i = 0; i < int'(n); i++) b.push_back(8'($urandom));
      rx_ready = 1'b0;
      got.delete();
      cs_low();
      foreach (b[i]) xfer_byte(b[i], m);
      cs_high();
      if (t == 0) begin
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== b[0] || rx_last !== 1'b0) begin
          errors++;
          $display("FAIL ovf_offer got=%b/%h/%b want=1/%h/0", rx_valid, rx_data, rx_last, b[0]);
        end
      end
      checks++;
      if (overflow !== logic'(n > 2)) begin
        errors++;
        $display("FAIL ovf_flag n=%0d got=%b want=%b", n, overflow, logic'(n > 2));
      end
      rx_ready = 1'b1;
      #200;
      checks++;
      if (got.size() !== del) begin
        errors++;
        $display("FAIL ovf_count n=%0d got=%0d want=%0d", n, got.size(), del);
      end else begin
        for (int i = 0; i < int'(del); i++) begin
          checks++;
          if (got[i].d !== b[i] || got[i].l !== logic'(i == del - 1)) begin
            errors++;
            $display("FAIL ovf_byte n=%0d i=%0d got=%h/%b want=%h/%b", n, i,
                     got[i].d, got[i].l, b[i], logic'(i == del - 1));
          end
        end
      end
    end
    cs_low();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got=%b want=0", overflow);
    end
    cs_high();
  endtask

  task automatic test_partial();
    logic       mb;
    logic [7:0] x, m;
    rx_ready = 1'b1;
    got.delete();
    cs_low();
    for (int i = 0; i < 5; i++) xfer_bit(1'($urandom), mb);
    cs_high();
    checks++;
    if (got.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL partial_drop bytes=%0d busy=%b want 0/0", got.size(), busy);
    end
    x = 8'($urandom);
    cs_low();
    xfer_byte(x, m);
    cs_high();
    checks++;
    if (got.size() !== 1 || got[0].d !== x || got[0].l !== 1'b1) begin
      errors++;
      $display("FAIL partial_next bytes=%0d got=%h want=%h/1", got.size(),
               got.size() != 0 ? got[0].d : 8'h00, x);
    end
  endtask

  task automatic test_reset_mid();
    logic       mb;
    logic [7:0] x, m;
    rx_ready = 1'b1;
    cs_low();
    for (int i = 0; i < 4; i++) xfer_bit(1'($urandom), mb);
    RESET = 1'b1;
    #30;
    checks++;
    if ({MISO, MISO_OE, rx_valid, busy, tx_ready, overflow, underrun} !== 7'b0) begin
      errors++;
      $display("FAIL midreset_outputs got=%b want=0000000",
               {MISO, MISO_OE, rx_valid, busy, tx_ready, overflow, underrun});
    end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    got.delete();
    busy_seen = 1'b0;
    for (int i = 0; i < 16; i++) xfer_bit(1'($urandom), mb);
    #100;
    checks++;
    if (busy_seen !== 1'b0 || got.size() !== 0 || MISO_OE !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ignored busy_seen=%b bytes=%0d oe=%b want 0/0/0",
               busy_seen, got.size(), MISO_OE);
    end
    CS_n = 1'b1;
    #100;
    x = 8'($urandom);
    cs_low();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_rearm busy=%b want=1", busy);
    end
    xfer_byte(x, m);
    cs_high();
    checks++;
    if (got.size() !== 1 || got[0].d !== x || got[0].l !== 1'b1) begin
      errors++;
      $display("FAIL midreset_next bytes=%0d got=%h want=%h/1", got.size(),
               got.size() != 0 ? got[0].d : 8'h00, x);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    CS_n = 1'b1;
    SCK = 1'b0;
    MOSI = 1'b0;
    rx_ready = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    test_reset();
    test_rx_stream();
    test_tx();
    test_underrun();
    test_overflow();
    test_partial();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
